// File: rtl/store_stage_pkg.sv
// store_stage_pkg: storage-kind encoding, special register IDs and vector widths shared with execute.
package store_stage_pkg;
    localparam int LANE_W = 64;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_PC = 5'd31;
    localparam logic [REG_W-1:0] REG_FLAGS = 5'd30;
    typedef enum logic [2:0] {
        HALT                 = 3'd0,
        JMP                  = 3'd1,
        CJMP                 = 3'd2,
        LOAD_MEM_INTO_REG    = 3'd3,
        STORE_VALUE_INTO_REG = 3'd4,
        STORE_REG_INTO_MEM   = 3'd5
    } storage_kind_t;
    typedef enum logic [2:0] {
        IDLE, MEM_REQ, MEM_WAIT, WRITEBACK, REDIR1, REDIR2, HALTED
    } store_state_t;
    function automatic int lane_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/store_lane_sequencer.sv
// store_lane_sequencer: holds the current lane and finds the first / next active lane of a mask.
module store_lane_sequencer #(
    parameter int N = 4,
    parameter int LW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  mask,
    input  logic          start,
    input  logic          advance,
    output logic [LW-1:0] lane,
    output logic [LW-1:0] first_lane,
    output logic          next_valid
);
    logic [LW-1:0] next_lane;
    always_comb begin
        first_lane = '0;
        next_lane = '0;
        next_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) first_lane = LW'(i);
            if (mask[i] && i > int'(lane)) begin
                next_lane = LW'(i);
                next_valid = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) lane <= '0;
        else if (start) lane <= first_lane;
        else if (advance) lane <= next_lane;
    end
endmodule

// File: rtl/store_stage.sv
// store_stage: sequences memory, register-file writeback and redirect traffic for one execute packet.
module store_stage import store_stage_pkg::*; #(
    parameter int NUM_THREADS = 4,
    parameter int CORE_ID = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_busy,
    input  storage_kind_t                 in_kind,
    input  logic [NUM_THREADS-1:0]        in_mask,
    input  logic [63:0]                   in_pc,
    input  logic [REG_W-1:0]              in_reg,
    input  logic                          in_restore_pc,
    input  logic [LANE_W*NUM_THREADS-1:0] in_addr,
    input  logic [LANE_W*NUM_THREADS-1:0] in_data,
    input  logic [63:0]                   in_addr2,
    input  logic [NUM_THREADS-1:0]        in_mask1,
    input  logic [NUM_THREADS-1:0]        in_mask2,
    output logic                          mem_req_valid,
    output logic                          mem_req_write,
    output logic [63:0]                   mem_req_addr,
    output logic [63:0]                   mem_req_wdata,
    input  logic                          mem_req_ready,
    input  logic                          mem_rsp_valid,
    input  logic [63:0]                   mem_rsp_rdata,
    output logic                          rf_wr_en,
    output logic [REG_W-1:0]              rf_wr_reg,
    output logic [LANE_W*NUM_THREADS-1:0] rf_wr_data,
    output logic [NUM_THREADS-1:0]        rf_wr_mask,
    output logic                          redir_valid,
    output logic [63:0]                   redir_pc,
    output logic [NUM_THREADS-1:0]        redir_mask,
    input  logic                          redir_ready,
    output logic                          halted
);
    localparam int VW = LANE_W * NUM_THREADS;
    localparam int LW = lane_bits(NUM_THREADS);
    store_state_t state, state_n;
    storage_kind_t kind_q;
    logic [NUM_THREADS-1:0] mask_q, mask1_q, mask2_q;
    logic [REG_W-1:0] reg_q;
    logic restore_q;
    logic [VW-1:0] addr_q, data_q, buf_q;
    logic [63:0] addr2_q;
    logic [LW-1:0] lane, first_lane;
    logic next_valid, accept, is_load, is_store, advance;
    assign accept = in_valid && !in_busy;
    assign is_load = kind_q == LOAD_MEM_INTO_REG;
    assign is_store = kind_q == STORE_REG_INTO_MEM;
    assign advance = (state == MEM_REQ && mem_req_ready && is_store) || (state == MEM_WAIT && mem_rsp_valid);
    store_lane_sequencer #(.N(NUM_THREADS), .LW(LW)) u_seq (
        .clk(clk),
        .reset_n(reset_n),
        .mask(state == IDLE ? in_mask : mask_q),
        .start(accept),
        .advance(advance),
        .lane(lane),
        .first_lane(first_lane),
        .next_valid(next_valid)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        in_busy = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr = '0;
        mem_req_wdata = '0;
        rf_wr_en = 1'b0;
        rf_wr_reg = '0;
        rf_wr_data = '0;
        rf_wr_mask = '0;
        redir_valid = 1'b0;
        redir_pc = '0;
        redir_mask = '0;
        halted = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    in_busy = 1'b0;
                    if (in_valid) begin
                        case (in_kind)
                            HALT: state_n = HALTED;
                            JMP: state_n = REDIR1;
                            CJMP: state_n = |in_mask1 ? REDIR1 : |in_mask2 ? REDIR2 : IDLE;
                            STORE_VALUE_INTO_REG: state_n = WRITEBACK;
                            LOAD_MEM_INTO_REG: state_n = |in_mask ? MEM_REQ : WRITEBACK;
                            STORE_REG_INTO_MEM: state_n = |in_mask ? MEM_REQ : IDLE;
                            default: state_n = IDLE;
                        endcase
                    end
                end
                MEM_REQ: begin
                    mem_req_valid = 1'b1;
                    mem_req_write = is_store;
                    mem_req_addr = addr_q[lane*LANE_W +: LANE_W];
                    mem_req_wdata = is_store ? data_q[lane*LANE_W +: LANE_W] : '0;
                    if (mem_req_ready) state_n = !is_store ? MEM_WAIT : next_valid ? MEM_REQ : IDLE;
                end
                MEM_WAIT: if (mem_rsp_valid) state_n = next_valid ? MEM_REQ : WRITEBACK;
                WRITEBACK: begin
                    rf_wr_en = 1'b1;
                    rf_wr_reg = is_load && restore_q ? REG_PC : reg_q;
                    rf_wr_data = is_load ? buf_q : addr_q;
                    rf_wr_mask = mask_q;
                    state_n = is_load && restore_q && |mask_q ? REDIR1 : IDLE;
                end
                REDIR1: begin
                    // a PC-restoring load redirects to the value loaded by its first active lane
                    redir_valid = 1'b1;
                    redir_pc = is_load ? buf_q[first_lane*LANE_W +: LANE_W] : addr_q[LANE_W-1:0];
                    redir_mask = kind_q == CJMP ? mask1_q : mask_q;
                    if (redir_ready) state_n = kind_q == CJMP && |mask2_q ? REDIR2 : IDLE;
                end
                REDIR2: begin
                    redir_valid = 1'b1;
                    redir_pc = addr2_q;
                    redir_mask = mask2_q;
                    if (redir_ready) state_n = IDLE;
                end
                HALTED: halted = 1'b1;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            kind_q <= in_kind;
            mask_q <= in_mask;
            mask1_q <= in_mask1;
            mask2_q <= in_mask2;
            reg_q <= in_reg;
            restore_q <= in_restore_pc;
            addr_q <= in_addr;
            data_q <= in_data;
            addr2_q <= in_addr2;
            buf_q <= '0;
        end else if (state == MEM_WAIT && mem_rsp_valid) begin
            buf_q[lane*LANE_W +: LANE_W] <= mem_rsp_rdata;
        end
        if (accept) begin
            assert (in_kind inside {HALT, JMP, CJMP, LOAD_MEM_INTO_REG, STORE_VALUE_INTO_REG, STORE_REG_INTO_MEM})
            else $error("store_stage core %0d: unknown kind %0d at pc %h", CORE_ID, in_kind, in_pc);
        end
    end
endmodule

// File: doc/store_stage.md
STORE_STAGE -- requirements
Module: store_stage

Interface
REQ-001 Parameter NUM_THREADS, default 4, lanes per vector; lane i occupies bits [64*i+63:64*i] of every vector port.
REQ-002 Parameter CORE_ID, default 0, printed in display messages only.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  reset is synchronous and active-low.
REQ-005 in_valid  in  1  execute presents a packet.
REQ-006 in_busy  out  1  high = packet not accepted; a packet is accepted when in_valid && !in_busy.
REQ-007 in_kind  in  3  storage_kind_t: HALT, JMP, CJMP, LOAD_MEM_INTO_REG, STORE_VALUE_INTO_REG, STORE_REG_INTO_MEM.
REQ-008 in_mask  in  NUM_THREADS  exec mask; in_pc  in  64  instruction PC; in_reg  in  5  destination reg ID; in_restore_pc  in  1  load targets PC.
REQ-009 in_addr  in  64*NUM_THREADS  per-lane address or value; in_data  in  64*NUM_THREADS  store data.
REQ-010 in_addr2  in  64  CJMP fall-through target; in_mask1/in_mask2  in  NUM_THREADS each  CJMP taken/not-taken masks.
REQ-011 mem_req_valid  out  1; mem_req_write  out  1; mem_req_addr  out  64; mem_req_wdata  out  64; mem_req_ready  in  1.
REQ-012 mem_rsp_valid  in  1; mem_rsp_rdata  in  64  one response per read, in order.
REQ-013 rf_wr_en  out  1; rf_wr_reg  out  5; rf_wr_data  out  64*NUM_THREADS; rf_wr_mask  out  NUM_THREADS; rf_wr_en also marks rf_wr_reg valid.
REQ-014 redir_valid  out  1; redir_pc  out  64; redir_mask  out  NUM_THREADS; redir_ready  in  1.
REQ-015 halted  out  1  sticky halt indication.

Function
REQ-016 States: IDLE, MEM_REQ, MEM_WAIT, WRITEBACK, REDIR1, REDIR2, HALTED.
REQ-017 in_busy low only in IDLE; packet fields captured into internal registers on accept.
REQ-018 HALT: IDLE -> HALTED next cycle; halted=1; stays until reset; in_busy=1.
REQ-019 JMP: IDLE -> REDIR1; redir_valid=1, redir_pc=in_addr lane 0, redir_mask=in_mask; on redir_ready -> IDLE.
REQ-020 CJMP: REDIR1 issues (in_addr lane 0, in_mask1), then REDIR2 issues (in_addr2, in_mask2), each waiting for redir_ready; a zero mask is skipped without asserting redir_valid.
REQ-021 STORE_VALUE_INTO_REG: IDLE -> WRITEBACK; rf_wr_en=1 one cycle with rf_wr_data=in_addr, rf_wr_mask=in_mask; then IDLE (total latency 2 cycles accept-to-write).
REQ-022 LOAD_MEM_INTO_REG / STORE_REG_INTO_MEM: lane counter walks lanes 0..NUM_THREADS-1 ascending, skipping lanes with mask bit 0.
REQ-023 MEM_REQ: mem_req_valid=1 with addr/wdata of current lane; held stable until mem_req_ready; store -> next lane; load -> MEM_WAIT.
REQ-024 MEM_WAIT: on mem_rsp_valid, rdata written into lane slot of result buffer; then next lane.
REQ-025 After last active lane: load -> WRITEBACK (rf_wr_reg = in_reg, or REG_PC when in_restore_pc=1); store -> IDLE.
REQ-026 Load restoring PC additionally issues redirect with redir_pc = loaded lane-0 value (first active lane) after WRITEBACK.
REQ-027 All-zero exec mask on memory kinds: no memory traffic; loads still perform WRITEBACK with rf_wr_mask=0.
REQ-028 Unknown in_kind: $display error with CORE_ID, assertion failure, return to IDLE.
REQ-029 Outputs not described as active in a state are 0.

Reset
REQ-030 While reset_n=0 at a rising edge: state=IDLE, lane counter=0, all outputs 0 except in_busy=1; first accept possible the cycle after reset_n rises.
REQ-031 Reset mid-transaction abandons it; an outstanding memory response arriving after reset is ignored.

Structure
REQ-032 storage_kind_t, REG_PC, REG_FLAGS, vector width constants live in the shared package used by the execute stage.
REQ-033 One sub-module natural: store_lane_sequencer (mask-driven next-active-lane finder and counter).

Verification
REQ-034 JMP pc=0x100, in_addr lane0=0x140, mask=4'b1111 -> redir_pc=0x140, mask 4'b1111, in_busy low again 1 cycle after redir_ready.
REQ-035 CJMP mask1=4'b0101, mask2=4'b1010, targets 0x200/0x108 -> two redirects in that order, redir_ready stalled 3 cycles on first.
REQ-036 LOAD reg 7, mask 4'b1011, addrs 0x10..0x40, rdata=addr+1 -> 3 reads lanes 0,1,3; rf_wr lane data {0x11,0x21,x,0x41}, mask 4'b1011.
REQ-037 STORE mask 4'b0110, mem_req_ready low 2 cycles per request -> exactly 2 writes, addr/wdata stable while stalled.
REQ-038 HALT then in_valid held -> halted=1, in_busy=1 forever; reset_n=0 during MEM_WAIT -> IDLE, late mem_rsp_valid ignored.
